// File: rtl/endme_multicycle_core.sv
// Multi-cycle EnDMe accumulator core: 9-bit ISA, req/ack instruction and data
// memory ports, carry/zero flags, HALT state and a saturating retire counter.
module endme_multicycle_core #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 16,
   parameter int RET_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [8:0]        imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halted,
   output logic [DATA_W-1:0] acc_out,
   output logic [1:0]        flags_out,
   output logic [RET_W-1:0]  retired
);

   // state  | meaning
   // IDLE   | out of reset, one cycle before the first fetch
   // FETCH  | imem_req high, waiting for imem_ack
   // EXEC   | decode and execute IR (single cycle)
   // MEM    | dmem_req high for LD/ST, waiting for dmem_ack
   // HALT   | stopped, only reset leaves
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [3:0] OP_MOVR = 4'h0;
   localparam logic [3:0] OP_MOVA = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_CMP  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [8:0] IR_NOP = 9'h0E0;

   logic [2:0]        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic              c_q, c_d, z_q, z_d;
   logic [8:0]        ir_q, ir_d;
   logic [RET_W-1:0]  ret_q, ret_d;
   logic              ret_inc;

   logic [3:0]        op;
   logic [DATA_W-1:0] rn;
   logic [DATA_W:0]   sum_w, diff_w, shl_w, shr_w;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   assign op = ir_q[7:4];
   assign rn = regs_q[ir_q[3:0]];

   // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
   always_comb begin
      sum_w   = {1'b0, acc_q} + {1'b0, rn};
      diff_w  = {1'b0, acc_q} - {1'b0, rn};
      shl_w   = {1'b0, acc_q} << rn[2:0];
      shr_w   = {acc_q, 1'b0} >> rn[2:0];
      alu_res = acc_q;
      alu_c   = c_q;
      case (op)
         OP_ADD:         begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  end
         OP_SUB, OP_CMP: begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; end
         OP_AND:         alu_res = acc_q & rn;
         OP_OR:          alu_res = acc_q | rn;
         OP_XOR:         alu_res = acc_q ^ rn;
         OP_SHL:         begin alu_res = shl_w[DATA_W-1:0];  alu_c = shl_w[DATA_W];  end
         OP_SHR:         begin alu_res = shr_w[DATA_W:1];    alu_c = shr_w[0];       end
         default:        ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      regs_d  = regs_q;
      c_d     = c_q;
      z_d     = z_q;
      ir_d    = ir_q;
      ret_inc = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (imem_ack) begin
            ir_d    = imem_rdata;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            ret_inc = 1'b1;
            if (ir_q[8]) begin
               acc_d = DATA_W'(ir_q[7:0]);
            end else begin
               case (op)
                  OP_MOVR: acc_d = rn;
                  OP_MOVA: regs_d[ir_q[3:0]] = acc_q;
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                     acc_d = alu_res;
                     z_d   = (alu_res == '0);
                     c_d   = alu_c;
                  end
                  OP_CMP: begin
                     z_d = (alu_res == '0);
                     c_d = alu_c;
                  end
                  OP_BZ:   if (z_q) pc_d = PC_W'(rn);
                  OP_JMP:  pc_d = PC_W'(rn);
                  OP_LD, OP_ST: begin
                     state_d = S_MEM;
                     ret_inc = 1'b0;
                  end
                  OP_HALT: state_d = S_HALT;
                  default: ;
               endcase
            end
         end
         S_MEM: if (dmem_ack) begin
            if (op == OP_LD) begin
               acc_d = dmem_rdata;
               z_d   = (dmem_rdata == '0);
            end
            ret_inc = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  ;
         default: state_d = S_IDLE;
      endcase
      ret_d = (ret_inc && (ret_q != '1)) ? ret_q + RET_W'(1) : ret_q;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         ir_q    <= IR_NOP;
         ret_q   <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         ir_q    <= ir_d;
         ret_q   <= ret_d;
         regs_q  <= regs_d;
      end
   end

   // Request strobes decode straight from state so async reset drops them at once.
   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = (state_q == S_MEM) && (op == OP_ST);
   assign dmem_addr  = rn;
   assign dmem_wdata = acc_q;
   assign halted     = (state_q == S_HALT);
   assign acc_out    = acc_q;
   assign flags_out  = {c_q, z_q};
   assign retired    = ret_q;

endmodule

// File: tb/tb_endme_multicycle_core.sv
// Directed bench for endme_multicycle_core: programs are loaded into a model ROM,
// the core is reset, and outputs are compared against hand-computed values.
module tb_endme_multicycle_core;

   logic        clk;
   logic        rst_n;
   logic        iack;
   int          dack_dly;
   int          dcnt;
   int          errors;
   int          checks;

   logic [8:0]  prog [0:65535];
   logic [7:0]  dmem_arr [0:255];

   logic        imem_req, dmem_req, dmem_we, halted, dmem_ack;
   logic [15:0] imem_addr;
   logic [8:0]  imem_rdata;
   logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata, acc_out;
   logic [1:0]  flags_out;
   logic [15:0] retired;

   logic        imem_req12, dmem_req12, dmem_we12, halted12;
   logic [15:0] imem_addr12;
   logic [8:0]  imem_rdata12;
   logic [11:0] dmem_addr12, dmem_wdata12, acc_out12;
   logic [1:0]  flags_out12;
   logic [15:0] retired12;

   endme_multicycle_core dut (
      .CLK(clk), .RESET(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(iack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .halted(halted), .acc_out(acc_out), .flags_out(flags_out), .retired(retired)
   );

   endme_multicycle_core #(.DATA_W(12)) dut12 (
      .CLK(clk), .RESET(rst_n),
      .imem_req(imem_req12), .imem_addr(imem_addr12), .imem_ack(iack), .imem_rdata(imem_rdata12),
      .dmem_req(dmem_req12), .dmem_we(dmem_we12), .dmem_addr(dmem_addr12), .dmem_wdata(dmem_wdata12),
      .dmem_ack(1'b0), .dmem_rdata(12'h000),
      .halted(halted12), .acc_out(acc_out12), .flags_out(flags_out12), .retired(retired12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata   = prog[imem_addr];
   assign imem_rdata12 = prog[imem_addr12];
   assign dmem_rdata   = dmem_arr[dmem_addr];
   assign dmem_ack     = dmem_req && (dcnt >= dack_dly);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dcnt <= 0;
      else if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   always @(posedge clk) begin
      if (dmem_req && dmem_ack && dmem_we) dmem_arr[dmem_addr] <= dmem_wdata;
   end

   function automatic logic [8:0] li(input logic [7:0] v);
      return {1'b1, v};
   endfunction

   function automatic logic [8:0] ins(input logic [3:0] op, input logic [3:0] n);
      return {1'b0, op, n};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 65536; i++) prog[i] = 9'h0F0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_prog();
      prog[0] = li(8'h55);
      prog[1] = ins(4'hA, 4'h0);
      dack_dly = 100;
      do_reset();
      step(5);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++;
         $display("FAIL reset_pre_st req/we got %b%b exp 11", dmem_req, dmem_we); end
      checks++; if (acc_out !== 8'h55) begin errors++;
         $display("FAIL reset_pre_acc got %h exp 55", acc_out); end
      checks++; if (retired !== 16'd1) begin errors++;
         $display("FAIL reset_pre_ret got %0d exp 1", retired); end
      rst_n = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin errors++;
         $display("FAIL reset_async_outs got req=%b we=%b ireq=%b h=%b exp 0", dmem_req, dmem_we, imem_req, halted); end
      checks++; if (acc_out !== 8'h00 || retired !== 16'd0 || flags_out !== 2'b00 || imem_addr !== 16'h0000) begin errors++;
         $display("FAIL reset_state got acc=%h ret=%0d fl=%b pc=%h exp 0", acc_out, retired, flags_out, imem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (imem_req !== 1'b0) begin errors++;
         $display("FAIL reset_idle ireq got %b exp 0", imem_req); end
      step(1);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++;
         $display("FAIL reset_first_fetch got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
      dack_dly = 0;
   endtask

   task automatic test_add();
      clear_prog();
      prog[0] = li(8'h05); prog[1] = ins(4'h1, 4'h1); prog[2] = li(8'h03);
      prog[3] = ins(4'h2, 4'h1); prog[4] = ins(4'h0, 4'h1); prog[5] = ins(4'hF, 4'h0);
      do_reset();
      step(9);
      checks++; if (acc_out !== 8'h08 || flags_out !== 2'b00 || retired !== 16'd4) begin errors++;
         $display("FAIL add got acc=%h fl=%b ret=%0d exp 08/00/4", acc_out, flags_out, retired); end
      step(2);
      checks++; if (acc_out !== 8'h05 || retired !== 16'd5) begin errors++;
         $display("FAIL add_movr_r1 got acc=%h ret=%0d exp 05/5", acc_out, retired); end
      step(4);
      checks++; if (halted !== 1'b1 || retired !== 16'd6) begin errors++;
         $display("FAIL add_halt got h=%b ret=%0d exp 1/6", halted, retired); end
   endtask

   task automatic test_carry_width();
      clear_prog();
      prog[0] = li(8'hFF); prog[1] = ins(4'h1, 4'h2); prog[2] = li(8'h01); prog[3] = ins(4'h2, 4'h2);
      do_reset();
      step(9);
      checks++; if (acc_out !== 8'h00 || flags_out !== 2'b11) begin errors++;
         $display("FAIL carry8 got acc=%h fl=%b exp 00/11", acc_out, flags_out); end
      checks++; if (acc_out12 !== 12'h100 || flags_out12 !== 2'b00) begin errors++;
         $display("FAIL carry12 got acc=%h fl=%b exp 100/00", acc_out12, flags_out12); end
   endtask

   task automatic test_branch();
      clear_prog();
      prog[0] = li(8'h10); prog[1] = ins(4'h1, 4'h3); prog[2] = ins(4'h4, 4'h0); prog[3] = ins(4'hB, 4'h3);
      prog[16'h10] = ins(4'hD, 4'h3); prog[16'h11] = ins(4'hB, 4'h3);
      prog[16'h12] = li(8'h30); prog[16'h13] = ins(4'h1, 4'h5); prog[16'h14] = ins(4'hC, 4'h5);
      do_reset();
      step(9);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || flags_out !== 2'b01) begin errors++;
         $display("FAIL bz_taken got req=%b addr=%h fl=%b exp 1/0010/01", imem_req, imem_addr, flags_out); end
      step(2);
      checks++; if (flags_out !== 2'b10) begin errors++;
         $display("FAIL cmp_ne got fl=%b exp 10", flags_out); end
      step(2);
      checks++; if (imem_addr !== 16'h0012) begin errors++;
         $display("FAIL bz_not_taken got addr=%h exp 0012", imem_addr); end
      step(6);
      checks++; if (imem_addr !== 16'h0030 || retired !== 16'd9) begin errors++;
         $display("FAIL jmp got addr=%h ret=%0d exp 0030/9", imem_addr, retired); end
   endtask

   task automatic test_mem();
      clear_prog();
      dmem_arr[8'h20] = 8'h00;
      prog[0] = li(8'h20); prog[1] = ins(4'h1, 4'h4); prog[2] = li(8'hAB); prog[3] = ins(4'hA, 4'h4);
      prog[4] = li(8'h00); prog[5] = ins(4'h9, 4'h4);
      dack_dly = 3;
      do_reset();
      step(9);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h20 || dmem_wdata !== 8'hAB || retired !== 16'd3) begin
            errors++;
            $display("FAIL st_hold[%0d] got req=%b we=%b a=%h d=%h ret=%0d exp 1/1/20/AB/3", i, dmem_req, dmem_we, dmem_addr, dmem_wdata, retired);
         end
         step(1);
      end
      checks++; if (dmem_req !== 1'b0 || retired !== 16'd4) begin errors++;
         $display("FAIL st_done got req=%b ret=%0d exp 0/4", dmem_req, retired); end
      step(4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h20 || acc_out !== 8'h00) begin errors++;
            $display("FAIL ld_hold[%0d] got req=%b we=%b a=%h acc=%h exp 1/0/20/00", i, dmem_req, dmem_we, dmem_addr, acc_out); end
         step(1);
      end
      checks++; if (acc_out !== 8'hAB || flags_out !== 2'b00 || retired !== 16'd6 || dmem_req !== 1'b0) begin errors++;
         $display("FAIL ld_done got acc=%h fl=%b ret=%0d req=%b exp AB/00/6/0", acc_out, flags_out, retired, dmem_req); end
      dack_dly = 0;
   endtask

   task automatic run_alu(input string name, input logic [3:0] op, input logic [7:0] r1,
                          input logic [7:0] a, input logic [7:0] exp_acc, input logic [1:0] exp_fl);
      clear_prog();
      prog[0] = li(r1); prog[1] = ins(4'h1, 4'h1); prog[2] = li(a); prog[3] = ins(op, 4'h1);
      do_reset();
      step(9);
      checks++; if (acc_out !== exp_acc || flags_out !== exp_fl) begin errors++;
         $display("FAIL alu_%s got acc=%h fl=%b exp %h/%b", name, acc_out, flags_out, exp_acc, exp_fl); end
   endtask

   task automatic test_alu_ops();
      run_alu("sub_borrow", 4'h3, 8'h07, 8'h05, 8'hFE, 2'b10);
      run_alu("sub_zero",   4'h3, 8'h07, 8'h07, 8'h00, 2'b01);
      run_alu("and",        4'h4, 8'h3C, 8'hF0, 8'h30, 2'b00);
      run_alu("or",         4'h5, 8'h0F, 8'hF0, 8'hFF, 2'b00);
      run_alu("xor",        4'h6, 8'hAA, 8'hAA, 8'h00, 2'b01);
      run_alu("shl1",       4'h7, 8'h01, 8'h96, 8'h2C, 2'b10);
      run_alu("shl3",       4'h7, 8'h0B, 8'h96, 8'hB0, 2'b00);
      run_alu("shr2",       4'h8, 8'h02, 8'h96, 8'h25, 2'b10);
      run_alu("shr0",       4'h8, 8'h00, 8'h96, 8'h96, 2'b00);
      run_alu("cmp_eq",     4'hD, 8'h05, 8'h05, 8'h05, 2'b01);
      run_alu("nop",        4'hE, 8'h11, 8'h22, 8'h22, 2'b00);
      run_alu("add_wrap",   4'h2, 8'h80, 8'h80, 8'h00, 2'b11);
   endtask

   task automatic test_halt();
      clear_prog();
      iack = 1'b1;
      do_reset();
      step(3);
      for (int i = 0; i < 20; i++) begin
         checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || retired !== 16'd1) begin errors++;
            $display("FAIL halt_hold[%0d] got h=%b ireq=%b ret=%0d exp 1/0/1", i, halted, imem_req, retired); end
         step(1);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || retired !== 16'd0) begin errors++;
         $display("FAIL halt_reset got h=%b ret=%0d exp 0/0", halted, retired); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++;
         $display("FAIL halt_restart got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst_n    = 1'b0;
      iack     = 1'b1;
      dack_dly = 0;
      for (int i = 0; i < 256; i++) dmem_arr[i] = 8'h00;
      test_reset();
      test_add();
      test_carry_width();
      test_branch();
      test_mem();
      test_alu_ops();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
